// File: rtl/rv32im_dmem_ctrl_pkg.sv
// rv32im_dmem_ctrl_pkg: shared width, state, size and error encodings for the data-memory controller
package rv32im_dmem_ctrl_pkg;
   localparam int API_DATA_WIDTH = 32;
   typedef enum logic [2:0] {
      DMEM_IDLE  = 3'd0,
      DMEM_REQ   = 3'd1,
      DMEM_RESP  = 3'd2,
      DMEM_DONE  = 3'd3,
      DMEM_FAULT = 3'd4
   } dmem_state_e;
   typedef enum logic [1:0] {
      SIZE_B    = 2'd0,
      SIZE_H    = 2'd1,
      SIZE_W    = 2'd2,
      SIZE_RSVD = 2'd3
   } size_e;
   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_BUS      = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_e;
   // reserved size code falls through to the word rule
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      return (size == SIZE_H) ? a[0] : (size == SIZE_B) ? 1'b0 : |a;
   endfunction
endpackage

// File: rtl/rv32im_dmem_ctrl.sv
// rv32im_dmem_ctrl: single-outstanding req/gnt + rvalid bus controller behind rv32im_lsu
module rv32im_dmem_ctrl
   import rv32im_dmem_ctrl_pkg::*;
#(
   parameter int DATA_W  = API_DATA_WIDTH,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [3:0]        wmask_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic              bus_req_o,
   input  logic              bus_gnt_i,
   output logic              bus_we_o,
   output logic [3:0]        bus_be_o,
   output logic [DATA_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_rvalid_i,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_err_i
);
   dmem_state_e       state, state_nxt;
   err_e              err_q;
   logic              we_q;
   logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
   logic [3:0]        be_q;
   logic [7:0]        cnt;
   logic              mis, tmo, fin, accept;
   assign mis    = misaligned(size_i, addr_i[1:0]);
   assign tmo    = cnt == 8'(TIMEOUT - 1);
   assign accept = state == DMEM_IDLE && req_i;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state <= DMEM_IDLE;
      else         state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         DMEM_IDLE: if (req_i) state_nxt = mis ? DMEM_FAULT : DMEM_REQ;
         DMEM_REQ:  if (bus_gnt_i) state_nxt = DMEM_RESP;
         DMEM_RESP: if (bus_rvalid_i || tmo) state_nxt = DMEM_DONE;
         default:   state_nxt = DMEM_IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         err_q   <= ERR_NONE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
         cnt     <= '0;
      end else begin
         if (accept) begin
            err_q <= mis ? ERR_MISALIGN : ERR_NONE;
            if (!mis) begin
               we_q    <= we_i;
               addr_q  <= {addr_i[DATA_W-1:2], 2'b00};
               wdata_q <= wdata_i;
               be_q    <= we_i ? wmask_i : 4'hf;
            end
         end
         if (state == DMEM_REQ && bus_gnt_i) cnt <= '0;
         else if (state == DMEM_RESP)        cnt <= cnt + 8'd1;
         // rvalid takes priority over a timeout landing in the same cycle
         if (state == DMEM_RESP) begin
            if (bus_rvalid_i) begin
               err_q <= bus_err_i ? ERR_BUS : ERR_NONE;
               if (!we_q) rdata_q <= bus_rdata_i;
            end else if (tmo) begin
               err_q <= ERR_TIMEOUT;
            end
         end
      end
   assign fin         = state == DMEM_DONE || state == DMEM_FAULT;
   assign done_o      = fin;
   assign err_o       = fin && err_q != ERR_NONE;
   assign err_code_o  = err_q;
   assign rdata_o     = rdata_q;
   assign stall_o     = rst_ni && (state == DMEM_REQ || state == DMEM_RESP || accept);
   assign bus_req_o   = state == DMEM_REQ;
   assign bus_we_o    = bus_req_o && we_q;
   assign bus_be_o    = bus_req_o ? be_q : '0;
   assign bus_addr_o  = bus_req_o ? addr_q : '0;
   assign bus_wdata_o = bus_req_o ? wdata_q : '0;
endmodule

// File: tb/tb_rv32im_dmem_ctrl.sv
// tb_rv32im_dmem_ctrl: directed self-checking bench for the data-memory controller
module tb_rv32im_dmem_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0, we_i = 1'b0;
   logic [1:0]  size_i = 2'd0;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic [3:0]  wmask_i = '0;
   logic        stall_o, done_o, err_o;
   logic [31:0] rdata_o;
   logic [1:0]  err_code_o;
   logic        bus_req_o, bus_we_o;
   logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_err_i = 1'b0;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [31:0] bus_rdata_i = '0;
   int tests = 0, fails = 0;
   rv32im_dmem_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .wmask_i(wmask_i), .stall_o(stall_o),
      .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o), .err_code_o(err_code_o),
      .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o),
      .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
      .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask
   task automatic mid();
      @(negedge clk_i);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      // reset state
      cyc(); mid();
      chk("rst_stall", stall_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_code", err_code_o, 0);
      chk("rst_busreq", bus_req_o, 0);
      cyc(); rst_ni = 1'b1;
      // load word, immediate grant
      cyc(); req_i = 1; we_i = 0; size_i = 2; addr_i = 32'h8; bus_gnt_i = 1;
      mid(); chk("lw_c0_stall", stall_o, 1); chk("lw_c0_busreq", bus_req_o, 0);
      cyc(); mid();
      chk("lw_c1_busreq", bus_req_o, 1); chk("lw_c1_addr", bus_addr_o, 32'h8);
      chk("lw_c1_be", bus_be_o, 4'hf); chk("lw_c1_we", bus_we_o, 0); chk("lw_c1_stall", stall_o, 1);
      cyc(); bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h08439341;
      mid(); chk("lw_c2_stall", stall_o, 1); chk("lw_c2_busreq", bus_req_o, 0); chk("lw_c2_done", done_o, 0);
      cyc(); bus_rvalid_i = 0; req_i = 0;
      mid(); chk("lw_c3_done", done_o, 1); chk("lw_c3_stall", stall_o, 0);
      chk("lw_c3_rdata", rdata_o, 32'h08439341); chk("lw_c3_err", err_o, 0);
      cyc(); mid(); chk("lw_c4_done", done_o, 0);
      // store byte, grant delayed three cycles
      cyc(); req_i = 1; we_i = 1; size_i = 0; addr_i = 32'h5; wmask_i = 4'b0010; wdata_i = 32'h00009300;
      mid(); chk("sb_c0_stall", stall_o, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(); if (i == 2) bus_gnt_i = 1;
         mid();
         chk("sb_busreq", bus_req_o, 1); chk("sb_be", bus_be_o, 4'b0010);
         chk("sb_addr", bus_addr_o, 32'h4); chk("sb_we", bus_we_o, 1);
         chk("sb_wdata", bus_wdata_o, 32'h00009300);
      end
      cyc(); bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'hdeadbeef;
      mid(); chk("sb_resp_busreq", bus_req_o, 0); chk("sb_resp_done", done_o, 0);
      cyc(); bus_rvalid_i = 0; req_i = 0;
      mid(); chk("sb_done", done_o, 1); chk("sb_rdata_kept", rdata_o, 32'h08439341); chk("sb_err", err_o, 0);
      // misaligned word then half
      cyc(); req_i = 1; we_i = 0; size_i = 2; addr_i = 32'h7;
      mid(); chk("mw_stall", stall_o, 1);
      cyc(); req_i = 0;
      mid(); chk("mw_done", done_o, 1); chk("mw_err", err_o, 1); chk("mw_code", err_code_o, 1);
      chk("mw_busreq", bus_req_o, 0); chk("mw_stall_f", stall_o, 0); chk("mw_rdata", rdata_o, 32'h08439341);
      cyc(); mid(); chk("mw_code_held", err_code_o, 1); chk("mw_done_low", done_o, 0);
      cyc(); req_i = 1; size_i = 1; addr_i = 32'h3;
      mid(); chk("mh_busreq0", bus_req_o, 0);
      cyc(); req_i = 0;
      mid(); chk("mh_done", done_o, 1); chk("mh_err", err_o, 1); chk("mh_code", err_code_o, 1); chk("mh_busreq", bus_req_o, 0);
      // bus error on load
      cyc(); req_i = 1; size_i = 2; addr_i = 32'h10; bus_gnt_i = 1;
      cyc(); mid(); chk("be_code_clr", err_code_o, 0); chk("be_addr", bus_addr_o, 32'h10);
      cyc(); bus_gnt_i = 0; bus_rvalid_i = 1; bus_err_i = 1; bus_rdata_i = 32'h11223344;
      cyc(); bus_rvalid_i = 0; bus_err_i = 0; req_i = 0;
      mid(); chk("be_done", done_o, 1); chk("be_err", err_o, 1); chk("be_code", err_code_o, 2); chk("be_rdata", rdata_o, 32'h11223344);
      // timeout: grant at cycle 1, done at cycle 257
      cyc(); req_i = 1; addr_i = 32'h20; bus_gnt_i = 1;
      cyc(); mid(); chk("to_busreq", bus_req_o, 1);
      cyc(); bus_gnt_i = 0;
      n = 0;
      for (int i = 0; i < 255; i++) begin
         mid(); if (done_o !== 1'b0 || stall_o !== 1'b1) n++;
         cyc();
      end
      chk("to_wait_cycles", n, 0);
      req_i = 0;
      mid(); chk("to_done", done_o, 1); chk("to_err", err_o, 1); chk("to_code", err_code_o, 3);
      cyc(); bus_rvalid_i = 1; bus_rdata_i = 32'h00000bad;
      mid(); chk("late_done", done_o, 0);
      cyc(); bus_rvalid_i = 0;
      mid(); chk("late_done2", done_o, 0); chk("late_rdata", rdata_o, 32'h11223344);
      chk("late_busreq", bus_req_o, 0); chk("late_code", err_code_o, 3);
      // asynchronous reset in the middle of RESP
      cyc(); req_i = 1; addr_i = 32'h30; bus_gnt_i = 1;
      cyc(); cyc(); bus_gnt_i = 0;
      #2 rst_ni = 0;
      #1;
      chk("ar_stall", stall_o, 0); chk("ar_busreq", bus_req_o, 0); chk("ar_done", done_o, 0);
      chk("ar_rdata", rdata_o, 0); chk("ar_code", err_code_o, 0); chk("ar_err", err_o, 0);
      cyc(); rst_ni = 1; req_i = 0;
      mid(); chk("ar_idle_stall", stall_o, 0); chk("ar_idle_busreq", bus_req_o, 0);
      cyc(); req_i = 1; addr_i = 32'h40; bus_gnt_i = 1;
      cyc(); mid(); chk("ar_lw_busreq", bus_req_o, 1); chk("ar_lw_addr", bus_addr_o, 32'h40);
      cyc(); bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'hcafef00d;
      cyc(); bus_rvalid_i = 0; req_i = 0;
      mid(); chk("ar_lw_done", done_o, 1); chk("ar_lw_rdata", rdata_o, 32'hcafef00d); chk("ar_lw_err", err_o, 0);
      cyc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
